// File: rtl/sram_req_arbiter.sv
// rtl/sram_req_arbiter.sv - fetch/data arbiter onto one SRAM-like port with in-order response routing
`timescale 1ns/1ps
module sram_req_arbiter #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int STARVE_LIMIT    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        req,
    output logic        wr,
    output logic [1:0]  size,
    output logic [3:0]  wstrb,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    input  logic        addr_ok,
    input  logic        data_ok,
    input  logic [31:0] rdata,
    output logic        resp_err
);

    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int SC_W  = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(MAX_OUTSTANDING);
    localparam logic [SC_W-1:0]  STARVE_MAX = SC_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD_I = 2'd1,
        HOLD_D = 2'd2
    } state_e;

    state_e            state_q;
    logic              ids_q [MAX_OUTSTANDING];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [SC_W-1:0]   starve_cnt_q, starve_cnt_d;
    logic              resp_err_q, resp_err_d;

    logic full, inst_starved, pick_d, pick_i, rearb;
    logic sel_i, sel_d, grant_i, grant_d, hs, pop, head_id;

    // Winner selection: data first unless fetch has lost STARVE_LIMIT times in a row;
    // a held side keeps the grant until addr_ok or until it withdraws its request.
    assign full         = (count_q == FULL_CNT);
    assign inst_starved = inst_req & (starve_cnt_q == STARVE_MAX);
    assign pick_d       = data_req & ~inst_starved;
    assign pick_i       = inst_req & ~pick_d;
    assign rearb        = (state_q == IDLE)
                        | ((state_q == HOLD_I) & ~inst_req)
                        | ((state_q == HOLD_D) & ~data_req);
    assign sel_i        = rearb ? pick_i : (state_q == HOLD_I);
    assign sel_d        = rearb ? pick_d : (state_q == HOLD_D);
    assign grant_i      = sel_i & ~full & ~reset;
    assign grant_d      = sel_d & ~full & ~reset;

    assign req          = grant_i | grant_d;
    assign hs           = req & addr_ok;
    assign inst_addr_ok = grant_i & addr_ok;
    assign data_addr_ok = grant_d & addr_ok;

    // Shared request fields follow the granted side; zero when nothing is granted.
    always_comb begin
        wr    = 1'b0;
        size  = 2'd0;
        wstrb = 4'd0;
        addr  = 32'd0;
        wdata = 32'd0;
        if (grant_d) begin
            wr    = data_wr;
            size  = data_size;
            wstrb = data_wstrb;
            addr  = data_addr;
            wdata = data_wdata;
        end else if (grant_i) begin
            wr    = inst_wr;
            size  = inst_size;
            wstrb = inst_wstrb;
            addr  = inst_addr;
            wdata = inst_wdata;
        end
    end

    // Responses come back in issue order, so the FIFO head names the owner.
    assign head_id      = ids_q[rd_ptr_q];
    assign pop          = data_ok & (count_q != '0) & ~reset;
    assign inst_data_ok = pop & ~head_id;
    assign data_data_ok = pop & head_id;
    assign inst_rdata   = reset ? 32'd0 : rdata;
    assign data_rdata   = reset ? 32'd0 : rdata;
    assign resp_err     = resp_err_q & ~reset;

    // Next-state for FIFO pointers, occupancy, starvation counter and the sticky error.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        starve_cnt_d = starve_cnt_q;
        resp_err_d   = resp_err_q | (data_ok & (count_q == '0));
        if (hs) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (hs && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!hs && pop) begin
            count_d = count_q - 1'b1;
        end
        if (hs && grant_i) begin
            starve_cnt_d = '0;
        end else if (hs && grant_d && inst_req) begin
            if (starve_cnt_q != STARVE_MAX) begin
                starve_cnt_d = starve_cnt_q + 1'b1;
            end
        end else if ((state_q == IDLE) && !inst_req) begin
            starve_cnt_d = '0;
        end
    end

    // Arbitration FSM: park on the winner while the port has not accepted the address.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else if (grant_d && !addr_ok) begin
            state_q <= HOLD_D;
        end else if (grant_i && !addr_ok) begin
            state_q <= HOLD_I;
        end else begin
            state_q <= IDLE;
        end
    end

    // Bookkeeping registers; reset empties the FIFO by clearing its pointers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            starve_cnt_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            starve_cnt_q <= starve_cnt_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // ID storage: records which side owns each accepted address phase.
    always_ff @(posedge clk) begin
        if (hs) begin
            ids_q[wr_ptr_q] <= grant_d;
        end
    end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// tb/tb_sram_req_arbiter.sv - scoreboard bench for sram_req_arbiter
`timescale 1ns/1ps
module tb_sram_req_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size, size;
    logic [3:0]  inst_wstrb, data_wstrb, wstrb;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        req, wr, addr_ok, data_ok, resp_err;
    logic [31:0] addr, wdata, rdata;

    typedef struct {
        bit          id;
        logic [31:0] data;
    } exp_t;

    int   total = 0;
    int   bad   = 0;
    bit   order_q[$];
    exp_t exp_q[$];
    exp_t mon_e;

    sram_req_arbiter #(.MAX_OUTSTANDING(4), .STARVE_LIMIT(8)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .req(req), .wr(wr), .size(size), .wstrb(wstrb), .addr(addr), .wdata(wdata),
        .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_wstrb = 4'hF;
        inst_addr = 32'h0; inst_wdata = 32'h0;
        data_req = 0; data_wr = 0; data_size = 2'd2; data_wstrb = 4'h0;
        data_addr = 32'h0; data_wdata = 32'h0;
        addr_ok = 0; data_ok = 0; rdata = 32'h0;
    endtask

    // Inputs change 1 ns after the rising edge; checks run 4 ns after it.
    task automatic cyc();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic resp(input logic [31:0] v);
        exp_t e;
        data_ok = 1;
        rdata   = v;
        if (order_q.size() != 0) begin
            e.id   = order_q.pop_front();
            e.data = v;
            exp_q.push_back(e);
        end
    endtask

    // Monitor: every response the DUT presents must match the scoreboard head.
    always @(negedge clk) begin
        if (inst_data_ok || data_data_ok) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_resp inst_ok=%0b data_ok=%0b required=none",
                         inst_data_ok, data_data_ok);
            end else begin
                mon_e = exp_q.pop_front();
                chk("resp_side", {30'd0, inst_data_ok, data_data_ok}, mon_e.id ? 32'd1 : 32'd2);
                chk("resp_rdata", mon_e.id ? data_rdata : inst_rdata, mon_e.data);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        idle_inputs();
        reset = 1;
        @(posedge clk);
        #1;
        inst_req = 1; inst_addr = 32'h1C00_0000; addr_ok = 1;
        settle();
        chk("rst_req", req, 0);
        chk("rst_inst_addr_ok", inst_addr_ok, 0);
        chk("rst_addr", addr, 0);

        cyc(); reset = 0; settle();
        chk("post_rst_req", req, 0);
        chk("post_rst_addr", addr, 0);
        chk("post_rst_err", resp_err, 0);

        // Single fetch.
        cyc(); inst_req = 1; inst_addr = 32'h1C00_0000; addr_ok = 1; settle();
        chk("fetch_req", req, 1);
        chk("fetch_addr", addr, 32'h1C00_0000);
        chk("fetch_inst_addr_ok", inst_addr_ok, 1);
        chk("fetch_data_addr_ok", data_addr_ok, 0);
        order_q.push_back(0);
        cyc(); settle();
        chk("fetch_count", 32'(dut.count_q), 1);
        cyc(); resp(32'h0280_0413); settle();
        chk("fetch_inst_data_ok", inst_data_ok, 1);
        chk("fetch_inst_rdata", inst_rdata, 32'h0280_0413);
        chk("fetch_data_data_ok", data_data_ok, 0);

        // Conflict: data wins, fetch follows once data drops.
        cyc();
        inst_req = 1; inst_addr = 32'h0000_0100;
        data_req = 1; data_addr = 32'h0000_2000; data_wr = 1; data_wstrb = 4'hF; addr_ok = 1;
        settle();
        chk("conf_addr", addr, 32'h0000_2000);
        chk("conf_wr", wr, 1);
        chk("conf_data_addr_ok", data_addr_ok, 1);
        chk("conf_inst_addr_ok", inst_addr_ok, 0);
        order_q.push_back(1);
        cyc(); inst_req = 1; inst_addr = 32'h0000_0100; addr_ok = 1; settle();
        chk("conf2_addr", addr, 32'h0000_0100);
        chk("conf2_inst_addr_ok", inst_addr_ok, 1);
        order_q.push_back(0);
        cyc(); resp(32'h1111_1111);
        cyc(); resp(32'h2222_2222);
        cyc();

        // Hold: data granted, address not accepted for three cycles.
        for (int k = 1; k <= 4; k++) begin
            cyc();
            inst_req = 1; inst_addr = 32'h1C00_0004; inst_wstrb = 4'hF;
            data_req = 1; data_addr = 32'h0000_3000; data_wstrb = 4'b0011;
            addr_ok = (k == 4);
            settle();
            chk($sformatf("hold%0d_addr", k), addr, 32'h0000_3000);
            chk($sformatf("hold%0d_wstrb", k), 32'(wstrb), 32'h3);
            chk($sformatf("hold%0d_inst_addr_ok", k), inst_addr_ok, 0);
            chk($sformatf("hold%0d_data_addr_ok", k), data_addr_ok, (k == 4) ? 1 : 0);
        end
        order_q.push_back(1);
        cyc(); settle();
        chk("hold_state_idle", 32'(dut.state_q), 0);
        chk("hold_idle_req", req, 0);
        cyc(); resp(32'h3333_3333);
        cyc();

        // Starvation: eight data wins, then fetch on the ninth.
        for (int k = 1; k <= 10; k++) begin
            cyc();
            inst_req = 1; inst_addr = 32'h1C00_0100;
            data_req = 1; data_addr = 32'h8000_0000 + 32'(k); addr_ok = 1;
            if (k > 1) resp(32'hA000_0000 + 32'(k));
            settle();
            chk($sformatf("starve%0d_inst_addr_ok", k), inst_addr_ok, (k == 9) ? 1 : 0);
            chk($sformatf("starve%0d_data_addr_ok", k), data_addr_ok, (k == 9) ? 0 : 1);
            if (k == 9) chk("starve9_cnt", 32'(dut.starve_cnt_q), 8);
            if (k == 10) chk("starve10_cnt", 32'(dut.starve_cnt_q), 0);
            order_q.push_back((k == 9) ? 1'b0 : 1'b1);
        end
        cyc(); resp(32'hA000_00FF);
        cyc();

        // Full and ordering.
        for (int k = 0; k < 4; k++) begin
            cyc();
            if (k % 2 == 0) begin inst_req = 1; inst_addr = 32'h40 + 32'(k); end
            else begin data_req = 1; data_addr = 32'h50 + 32'(k); end
            addr_ok = 1;
            settle();
            chk($sformatf("fill%0d_addr_ok", k), {30'd0, inst_addr_ok, data_addr_ok},
                (k % 2 == 0) ? 32'd2 : 32'd1);
            order_q.push_back((k % 2) != 0);
        end
        cyc(); inst_req = 1; addr_ok = 1; settle();
        chk("full_count", 32'(dut.count_q), 4);
        chk("full_req", req, 0);
        chk("full_inst_addr_ok", inst_addr_ok, 0);
        cyc(); inst_req = 1; addr_ok = 1; resp(32'hB000_0001); settle();
        chk("full_pop_req", req, 0);
        cyc(); inst_req = 1; inst_addr = 32'h60; addr_ok = 1; resp(32'hB000_0002); settle();
        chk("pp_count_before", 32'(dut.count_q), 3);
        chk("pp_req", req, 1);
        chk("pp_inst_addr_ok", inst_addr_ok, 1);
        order_q.push_back(0);
        cyc(); inst_req = 1; inst_addr = 32'h64; addr_ok = 1; settle();
        chk("pp_count_after", 32'(dut.count_q), 3);
        chk("pp_next_req", req, 1);
        order_q.push_back(0);
        for (int k = 0; k < 4; k++) begin
            cyc(); resp(32'hC000_0000 + 32'(k));
        end
        cyc(); settle();
        chk("drain_count", 32'(dut.count_q), 0);
        chk("drain_scoreboard", 32'(exp_q.size()), 0);

        // Cancel from HOLD_D: fetch wins in the same cycle, nothing pushed for data.
        cyc(); inst_req = 1; inst_addr = 32'h1C00_0200; data_req = 1; data_addr = 32'h7000; settle();
        chk("cancel_hold_addr", addr, 32'h7000);
        cyc(); inst_req = 1; inst_addr = 32'h1C00_0200; addr_ok = 1; settle();
        chk("cancel_req", req, 1);
        chk("cancel_addr", addr, 32'h1C00_0200);
        chk("cancel_inst_addr_ok", inst_addr_ok, 1);
        chk("cancel_data_addr_ok", data_addr_ok, 0);
        order_q.push_back(0);
        cyc(); settle();
        chk("cancel_count", 32'(dut.count_q), 1);
        cyc(); resp(32'hD000_0000);
        cyc();

        // Response with empty FIFO.
        cyc(); resp(32'h0000_0005); settle();
        chk("err_no_inst_ok", inst_data_ok, 0);
        chk("err_no_data_ok", data_data_ok, 0);
        chk("err_not_yet", resp_err, 0);
        cyc(); settle();
        chk("err_set", resp_err, 1);
        cyc(); cyc(); cyc(); settle();
        chk("err_sticky", resp_err, 1);

        // Reset with three outstanding.
        for (int k = 0; k < 3; k++) begin
            cyc(); inst_req = 1; inst_addr = 32'h90 + 32'(k); addr_ok = 1;
            order_q.push_back(0);
        end
        cyc(); settle();
        chk("pre_rst_count", 32'(dut.count_q), 3);
        reset = 1; inst_req = 1; addr_ok = 1; settle();
        chk("rst2_req", req, 0);
        chk("rst2_inst_addr_ok", inst_addr_ok, 0);
        cyc(); reset = 0; settle();
        order_q.delete();
        chk("rst2_count", 32'(dut.count_q), 0);
        chk("rst2_req_after", req, 0);
        chk("rst2_err_cleared", resp_err, 0);
        cyc(); resp(32'hE000_0000);
        cyc(); settle();
        chk("stale_resp_err", resp_err, 1);

        cyc();
        chk("final_scoreboard", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
